uart_bus_bridge: RTL and testbench
==================================

Name: uart_bus_bridge

Overview:
- Serial-to-bus initiator: host commands arrive from the FT2232 serial link and become read/write cycles on the 6809-side peripheral bus.
- It drives the request/RW/address/data side of the bus; memory or a peripheral answers with an acknowledge.
- Used for debug and monitor access (memory peek/poke) without running 6809 code.
- Own 16x-oversampled RX, own TX, command FSM.

Parameters:
- CLOCK_DIVISOR, 289, clk cycles per 1/16 bit (9600 bps x16 at 44.33 MHz).
- TIMEOUT_CYCLES, 1024, clk cycles to wait for i_bus_ack; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 44.33 MHz. One clock domain.
- reset  in  1  asynchronous, active-high reset.
- i_UART_TX  in  1  serial data from host (FT2232 TX); idle high.
- o_UART_RX  out  1  serial data to host (FT2232 RX); idle high.
- o_bus_req  out  1  bus cycle request; held until acknowledged.
- o_RW  out  1  1 = read, 0 = write; valid while o_bus_req = 1.
- o_addr  out  16  bus address; valid while o_bus_req = 1.
- o_wdata  out  8  write data; valid while o_bus_req = 1 and o_RW = 0.
- i_bus_ack  in  1  target acknowledge, one or more cycles high.
- i_rdata  in  8  read data; valid on the cycle i_bus_ack = 1.
- o_busy  out  1  high from command byte accepted until response stop bit sent.
- o_frame_err  out  1  one-cycle pulse when a received stop bit is 0.

Behaviour:
- Reset values: o_UART_RX = 1, o_bus_req = 0, o_RW = 1, o_addr = 0, o_wdata = 0, o_busy = 0, o_frame_err = 0. FSM goes to IDLE and all counters clear.
- Reset asserted mid-frame or mid-bus-cycle aborts at once; o_bus_req drops asynchronously.
- i_UART_TX passes through a 2-flop synchronizer. A tick enable fires every CLOCK_DIVISOR clks; there is no derived clock.
- RX, start detection:
  - Falling edge seen in RX idle starts a frame.
  - Start bit is re-sampled at tick 8; if high it is a glitch and RX returns to idle.
- RX, data and stop:
  - Data is sampled every 16 ticks, LSB first.
  - Stop bit is sampled at mid-bit.
  - Stop = 1: one-cycle rx_valid with the byte.
  - Stop = 0: o_frame_err pulses, the byte is discarded and the FSM returns to IDLE.
- Command FSM: IDLE -> ADDR_HI -> ADDR_LO -> [DATA] -> BUS -> RESP -> IDLE.
  - IDLE: 0x52 ('R') selects read, 0x57 ('W') selects write. Any other byte is ignored. o_busy rises on the cycle after an accepted command.
  - ADDR_HI, ADDR_LO: next bytes load o_addr[15:8], then o_addr[7:0].
  - DATA (write only): next byte loads o_wdata.
  - BUS: o_bus_req = 1 with addr/RW/wdata stable. On the first clk edge with i_bus_ack = 1, i_rdata is captured and o_bus_req = 0 on the next cycle.
  - A target holding ack high does not cause a second cycle; exactly one request per command.
  - RESP: response byte goes to TX. Read returns the captured data; write returns 0x4B ('K').
  - RESP -> IDLE after the stop bit completes; o_busy drops in the same cycle.
- Bytes received while in BUS or RESP are dropped. RX keeps framing so it stays in sync.
- TX: frame is 10 bits (start 0, 8 data LSB first, stop 1), each bit 16 ticks. Line is high between frames.
- Without BUS_TIMEOUT_EN, BUS waits indefinitely for ack.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: an 11-bit counter runs in BUS. If TIMEOUT_CYCLES clks pass with no ack:
  - o_bus_req drops;
  - response byte is 0x3F ('?');
  - FSM goes to RESP.
- Ack and timeout on the same edge: ack wins.
- Undefined: no counter; BUS waits forever.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - command/response constants CMD_READ = 8'h52, CMD_WRITE = 8'h57, RSP_OK = 8'h4B, RSP_ERR = 8'h3F;
  - FSM state encoding;
  - OVERSAMPLE = 16.
- One sub-module, uart_byte_rx: synchronizer, 16x receiver, rx_valid/rx_byte/frame_err.
- TX and the FSM stay in the top module.

Test Plan:
- 'W',0x12,0x34,0xA5 at 9600 bps, ack 3 cycles after req -> one req with o_RW = 0, o_addr = 0x1234, o_wdata = 0xA5; host receives 0x4B.
- 'R',0x80,0x00 with i_rdata = 0x5C on ack -> o_addr = 0x8000, o_RW = 1; host receives 0x5C; o_busy low after stop bit.
- Start glitch of 4 ticks, then bytes 0x00 and 0x41 -> no frame from the glitch, no bus cycle, o_busy stays 0.
- 'R' sent with stop bit forced 0 -> o_frame_err pulses once; FSM stays IDLE; a following valid read completes normally.
- With BUS_TIMEOUT_EN, 'R',0x00,0x10 and ack never asserted -> req drops after 1024 clks and host receives 0x3F. Without the macro, req stays high.
- Reset asserted during BUS state -> o_bus_req = 0 immediately, o_UART_RX = 1, no response byte sent.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encodings for the serial-to-bus debug bridge.
// Optional bus timeout is enabled by defining BUS_TIMEOUT_EN.
package uart_bridge_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int TICK_W     = $clog2(OVERSAMPLE);

   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h3F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_DATA,
      ST_BUS,
      ST_RESP
   } cmd_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Initiator-side bus of the bridge: request/RW/address/write data out,
// acknowledge and read data back from the addressed target.
interface uart_bus_bridge_if;

   logic        o_bus_req;
   logic        o_RW;
   logic [15:0] o_addr;
   logic [7:0]  o_wdata;
   logic        i_bus_ack;
   logic [7:0]  i_rdata;

   modport master (
      output o_bus_req, o_RW, o_addr, o_wdata,
      input  i_bus_ack, i_rdata
   );

   modport slave (
      input  o_bus_req, o_RW, o_addr, o_wdata,
      output i_bus_ack, i_rdata
   );

endinterface

// File: rtl/uart_byte_rx.sv
// 16x-oversampled UART receiver with input synchronizer; emits a one-cycle
// rx_valid with the byte, or a one-cycle frame_err when the stop bit is 0.
module uart_byte_rx
   import uart_bridge_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       rx_line,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   logic              sync1, sync2, rx_prev;
   rx_state_t         state, state_nx;
   logic [TICK_W-1:0] tick_cnt, tick_cnt_nx;
   logic [2:0]        bit_cnt, bit_cnt_nx;
   logic [7:0]        shift, shift_nx;
   logic              valid_nx, err_nx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         rx_prev   <= 1'b1;
         state     <= RX_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sync1     <= rx_line;
         sync2     <= sync1;
         rx_prev   <= sync2;
         state     <= state_nx;
         tick_cnt  <= tick_cnt_nx;
         bit_cnt   <= bit_cnt_nx;
         shift     <= shift_nx;
         rx_valid  <= valid_nx;
         frame_err <= err_nx;
      end
   end

   // NOTE: every output of this block gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_nx    = state;
      tick_cnt_nx = tick_cnt;
      bit_cnt_nx  = bit_cnt;
      shift_nx    = shift;
      valid_nx    = 1'b0;
      err_nx      = 1'b0;
      case (state)
         RX_IDLE: begin
            if (rx_prev && !sync2) begin
               state_nx    = RX_START;
               tick_cnt_nx = '0;
            end
         end
         RX_START: begin
            // Mid-start re-check rejects glitches shorter than half a bit.
            if (tick) begin
               tick_cnt_nx = tick_cnt + 1'b1;
               if (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1)) begin
                  tick_cnt_nx = '0;
                  bit_cnt_nx  = '0;
                  state_nx    = sync2 ? RX_IDLE : RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               tick_cnt_nx = tick_cnt + 1'b1;
               if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
                  shift_nx   = {sync2, shift[7:1]};
                  bit_cnt_nx = bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state_nx = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               tick_cnt_nx = tick_cnt + 1'b1;
               if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
                  state_nx = RX_IDLE;
                  valid_nx = sync2;
                  err_nx   = !sync2;
               end
            end
         end
         default: state_nx = RX_IDLE;
      endcase
   end

   assign rx_byte = shift;

endmodule

// File: rtl/uart_bus_bridge.sv
// Serial-to-bus initiator: 'R'/'W' host commands become single bus cycles and
// each is answered with one byte. Define BUS_TIMEOUT_EN to bound the ack wait.
module uart_bus_bridge
   import uart_bridge_pkg::*;
#(
   parameter int CLOCK_DIVISOR = 289
`ifdef BUS_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_UART_TX,
   output logic              o_UART_RX,
   uart_bus_bridge_if.master bus,
   output logic              o_busy,
   output logic              o_frame_err
);

   localparam int DIV_W = (CLOCK_DIVISOR > 1) ? $clog2(CLOCK_DIVISOR) : 1;

   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic              rx_valid;
   logic [7:0]        rx_byte;
   cmd_state_t        state, state_nx;
   logic              rw;
   logic [15:0]       addr;
   logic [7:0]        wdata;
   logic [7:0]        rsp_byte;
   logic [9:0]        tx_shift;
   logic [TICK_W-1:0] tx_tick_cnt;
   logic [3:0]        tx_bit_cnt;
   logic              tx_last;
   logic              timeout;
   logic              bus_req;
   logic              busy;
   logic              is_cmd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt == DIV_W'(CLOCK_DIVISOR - 1)) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         tick    <= 1'b0;
      end
   end

   uart_byte_rx u_rx (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .rx_line   (i_UART_TX),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .frame_err (o_frame_err)
   );

`ifdef BUS_TIMEOUT_EN
   logic [10:0] to_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                to_cnt <= '0;
      else if (state == ST_BUS) to_cnt <= to_cnt + 1'b1;
      else                      to_cnt <= '0;
   end

   assign timeout = (state == ST_BUS) && (to_cnt == 11'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   assign is_cmd  = (rx_byte == CMD_READ) || (rx_byte == CMD_WRITE);
   assign tx_last = tick && (tx_tick_cnt == TICK_W'(OVERSAMPLE - 1)) &&
                    (tx_bit_cnt == 4'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // Bytes arriving in BUS/RESP fall through untouched; the receiver keeps
   // framing on its own, so the next command still lines up.
   always_comb begin
      state_nx = state;
      bus_req  = 1'b0;
      busy     = 1'b1;
      rsp_byte = RSP_ERR;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (rx_valid && is_cmd) state_nx = ST_ADDR_HI;
         end
         ST_ADDR_HI: if (rx_valid) state_nx = ST_ADDR_LO;
         ST_ADDR_LO: if (rx_valid) state_nx = rw ? ST_BUS : ST_DATA;
         ST_DATA:    if (rx_valid) state_nx = ST_BUS;
         ST_BUS: begin
            bus_req = 1'b1;
            // Ack takes priority over a timeout landing on the same edge.
            if (bus.i_bus_ack) begin
               rsp_byte = rw ? bus.i_rdata : RSP_OK;
               state_nx = ST_RESP;
            end else if (timeout) begin
               state_nx = ST_RESP;
            end
         end
         ST_RESP: if (tx_last) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rw          <= 1'b1;
         addr        <= '0;
         wdata       <= '0;
         tx_shift    <= '1;
         tx_tick_cnt <= '0;
         tx_bit_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE:    if (rx_valid && is_cmd) rw <= (rx_byte == CMD_READ);
            ST_ADDR_HI: if (rx_valid) addr[15:8] <= rx_byte;
            ST_ADDR_LO: if (rx_valid) addr[7:0]  <= rx_byte;
            ST_DATA:    if (rx_valid) wdata      <= rx_byte;
            ST_BUS: begin
               if (bus.i_bus_ack || timeout) begin
                  tx_shift    <= {1'b1, rsp_byte, 1'b0};
                  tx_tick_cnt <= '0;
                  tx_bit_cnt  <= 4'd10;
               end
            end
            ST_RESP: begin
               if (tick) begin
                  tx_tick_cnt <= tx_tick_cnt + 1'b1;
                  if (tx_tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
                     tx_shift   <= {1'b1, tx_shift[9:1]};
                     tx_bit_cnt <= tx_bit_cnt - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_UART_RX     = tx_shift[0];
   assign o_busy        = busy;
   assign bus.o_bus_req = bus_req;
   assign bus.o_RW      = rw;
   assign bus.o_addr    = addr;
   assign bus.o_wdata   = wdata;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: table of host transactions against a
// simple acking target, plus glitch, framing-error, no-ack and reset sequences.
module tb_uart_bus_bridge;
   import uart_bridge_pkg::*;

   localparam int DIV      = 4;
   localparam int BIT_CLKS = DIV * OVERSAMPLE;
   localparam int GAP      = 16;

   typedef struct {
      logic [7:0]  cmd;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      logic        exp_rw;
      logic [7:0]  exp_resp;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic uart_tx = 1'b1;
   logic uart_rx, busy, frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   uart_bus_bridge_if bus ();

   uart_bus_bridge #(.CLOCK_DIVISOR(DIV)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_UART_TX   (uart_tx),
      .o_UART_RX   (uart_rx),
      .bus         (bus),
      .o_busy      (busy),
      .o_frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Target: ack two cycles long starting ~3 cycles after each request.
   logic        target_en = 1'b1;
   logic        req_q = 1'b0;
   logic [2:0]  ack_timer = 3'd0;
   int          req_count = 0;
   int          err_count = 0;
   logic [15:0] cap_addr = '0;
   logic        cap_rw = 1'b0;
   logic [7:0]  cap_wdata = '0;

   always @(negedge clk) begin
      req_q <= bus.o_bus_req;
      if (frame_err) err_count <= err_count + 1;
      if (bus.o_bus_req && !req_q) begin
         req_count <= req_count + 1;
         cap_addr  <= bus.o_addr;
         cap_rw    <= bus.o_RW;
         cap_wdata <= bus.o_wdata;
      end
      if (!target_en) begin
         bus.i_bus_ack <= 1'b0;
         ack_timer     <= 3'd0;
      end else if (bus.o_bus_req && !req_q) begin
         ack_timer <= 3'd1;
      end else if (ack_timer != 3'd0) begin
         bus.i_bus_ack <= (ack_timer == 3'd2) || (ack_timer == 3'd3);
         ack_timer     <= (ack_timer == 3'd4) ? 3'd0 : ack_timer + 3'd1;
      end else begin
         bus.i_bus_ack <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_tx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_tx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      uart_tx = stop_bit;
      repeat (BIT_CLKS) @(negedge clk);
      uart_tx = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic recv_byte(output logic [7:0] b, output logic ok);
      int waited = 0;
      b  = '0;
      ok = 1'b0;
      while (uart_rx && waited < 4000) begin
         @(negedge clk);
         waited++;
      end
      if (uart_rx) return;
      repeat (BIT_CLKS / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (BIT_CLKS) @(negedge clk);
         b[i] = uart_rx;
      end
      repeat (BIT_CLKS) @(negedge clk);
      ok = uart_rx;
   endtask

   task automatic wait_req(output logic seen);
      int waited = 0;
      while (!bus.o_bus_req && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      seen = bus.o_bus_req;
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] bytes [4];
      logic [7:0] rsp;
      logic       ok;
      int         n, rc0;
      bytes[0]    = v.cmd;
      bytes[1]    = v.addr[15:8];
      bytes[2]    = v.addr[7:0];
      bytes[3]    = v.wdata;
      n           = v.exp_rw ? 3 : 4;
      rc0         = req_count;
      bus.i_rdata = v.rdata;
      send_byte(bytes[0], 1'b1);
      check("busy_after_cmd", {31'd0, busy}, 32'd1);
      for (int i = 1; i < n - 1; i++) send_byte(bytes[i], 1'b1);
      fork
         send_byte(bytes[n-1], 1'b1);
         recv_byte(rsp, ok);
      join
      check("resp_stop_bit", {31'd0, ok}, 32'd1);
      check("resp_byte", {24'd0, rsp}, {24'd0, v.exp_resp});
      check("busy_in_stop", {31'd0, busy}, 32'd1);
      check("req_count", req_count - rc0, 32'd1);
      check("req_rw", {31'd0, cap_rw}, {31'd0, v.exp_rw});
      check("req_addr", {16'd0, cap_addr}, {16'd0, v.addr});
      if (!v.exp_rw) check("req_wdata", {24'd0, cap_wdata}, {24'd0, v.wdata});
      repeat (BIT_CLKS / 2 + 8) @(negedge clk);
      check("busy_after_stop", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [5];
      vec_t       v;
      logic [7:0] rsp;
      logic       ok, seen;
      int         rc0, e0, lows;

      vecs[0] = '{8'h57, 16'h1234, 8'hA5, 8'h00, 1'b0, 8'h4B};
      vecs[1] = '{8'h52, 16'h8000, 8'h00, 8'h5C, 1'b1, 8'h5C};
      vecs[2] = '{8'h57, 16'hFFFF, 8'h00, 8'hEE, 1'b0, 8'h4B};
      vecs[3] = '{8'h52, 16'h0001, 8'h00, 8'hFF, 1'b1, 8'hFF};
      vecs[4] = '{8'h52, 16'h00A5, 8'h00, 8'h00, 1'b1, 8'h00};

      bus.i_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_uart_rx", {31'd0, uart_rx}, 32'd1);
      check("rst_bus_req", {31'd0, bus.o_bus_req}, 32'd0);
      check("rst_rw", {31'd0, bus.o_RW}, 32'd1);
      check("rst_addr", {16'd0, bus.o_addr}, 32'd0);
      check("rst_wdata", {24'd0, bus.o_wdata}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;
      repeat (GAP) @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Four-tick start glitch, then two non-command bytes.
      rc0 = req_count;
      e0  = err_count;
      uart_tx = 1'b0;
      repeat (4 * DIV) @(negedge clk);
      uart_tx = 1'b1;
      repeat (BIT_CLKS * 2) @(negedge clk);
      check("glitch_busy", {31'd0, busy}, 32'd0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h41, 1'b1);
      check("ignored_busy", {31'd0, busy}, 32'd0);
      check("ignored_req", req_count - rc0, 32'd0);
      check("ignored_err", err_count - e0, 32'd0);

      // 'R' with a zero stop bit, then a normal read.
      send_byte(CMD_READ, 1'b0);
      check("frame_err_pulse", err_count - e0, 32'd1);
      check("frame_err_busy", {31'd0, busy}, 32'd0);
      check("frame_err_req", req_count - rc0, 32'd0);
      v = '{8'h52, 16'h4321, 8'h00, 8'h3C, 1'b1, 8'h3C};
      run_vec(v);

      // Target silent: request must hold (or time out when enabled).
      target_en = 1'b0;
      send_byte(CMD_READ, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      wait_req(seen);
      check("noack_req_seen", {31'd0, seen}, 32'd1);
`ifdef BUS_TIMEOUT_EN
      begin
         int n = 0;
         while (bus.o_bus_req && n < 2000) begin
            n++;
            @(negedge clk);
         end
         check("timeout_req_cycles", n, 32'd1024);
         recv_byte(rsp, ok);
         check("timeout_stop_bit", {31'd0, ok}, 32'd1);
         check("timeout_resp", {24'd0, rsp}, {24'd0, RSP_ERR});
         repeat (BIT_CLKS) @(negedge clk);
         send_byte(CMD_READ, 1'b1);
         send_byte(8'h00, 1'b1);
         send_byte(8'h10, 1'b1);
         wait_req(seen);
      end
`else
      repeat (1100) @(negedge clk);
      check("noack_req_held", {31'd0, bus.o_bus_req}, 32'd1);
`endif
      check("bus_addr_before_reset", {16'd0, bus.o_addr}, 32'h0010);

      // Reset in the middle of a clock period, while the request is up.
      #2;
      reset = 1'b1;
      #1;
      check("async_req_drop", {31'd0, bus.o_bus_req}, 32'd0);
      check("async_uart_rx", {31'd0, uart_rx}, 32'd1);
      check("async_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      lows = 0;
      for (int i = 0; i < BIT_CLKS * 12; i++) begin
         @(negedge clk);
         if (!uart_rx) lows++;
      end
      check("no_resp_after_reset", lows, 32'd0);
      check("idle_after_reset", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
